instr_fetch_unit: RTL and testbench

Instruction fetch unit: the initiator side of the instruction memory port. It owns the program counter and drives a byte address every cycle. It captures the returned 16-bit big-endian instruction word into a small in-order buffer and presents it to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts branch redirects and a sticky halt request from the core.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 86 ++++++++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    // Byte distance between consecutive 16-bit instruction words.
    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Instructions are halfword aligned; a redirect target is forced even.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & 16'hFFFE;
    endfunction

    // Sequential fetch address; wraps modulo 2^16 with no overflow flag.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: DEPTH-entry synchronous FIFO with flush.
// Flush beats push; a pop in the flush cycle is accepted and has no
// further effect because every entry is discarded anyway.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head_entry,
    output logic         not_empty,
    output logic         full
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    // A full buffer may still accept a push when the head leaves this cycle.
    assign do_pop     = pop & not_empty;
    assign do_push    = push & (~full | do_pop);
    assign full       = (count == FULL_COUNT);
    assign head_entry = mem[rd_ptr];

    // Next occupancy from flush, push and pop.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset because the head is visible on instr and must read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and the registered not-empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so all state samples pre-edge values.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
        end else begin
            count     <= count_next;
            not_empty <= (count_next != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap naturally.
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory
// address, buffers returned words and hands them to decode over
// valid/ready. Supports branch redirects and a sticky halt.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] im_addr,
    input  logic [15:0] im_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              buf_full;
    logic              do_pop;
    logic              do_push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // The memory sees the PC register directly; data returns in the same cycle.
    assign im_addr    = fetch_pc;
    assign push_entry = '{instr: im_data, pc: fetch_pc};

    // Decode takes the head when both sides agree.
    assign do_pop = instr_valid & instr_ready;

    // A redirect discards the word fetched at the old address this cycle.
    assign do_push = (state == RUN) & ~redirect_valid & (~buf_full | do_pop);

    assign instr    = head_entry.instr;
    assign instr_pc = head_entry.pc;

    // Program counter: redirect target, else advance on every accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (do_push) begin
            fetch_pc <= next_pc(fetch_pc);
        end
    end

    // Run/halt FSM with registered halted flag; redirect always resumes fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req && !redirect_valid) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // In-order buffer between memory and decode; redirect flushes it.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (do_push),
        .push_entry (push_entry),
        .pop        (do_pop),
        .head_entry (head_entry),
        .not_empty  (instr_valid),
        .full       (buf_full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a queue-level reference model
// predicts buffered words and the fetch address; a monitor compares the
// DUT head against the predicted queue on every accepted handshake.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int          BUF_DEPTH = 2;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] im_addr;
    logic [15:0] im_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        halted;

    logic [7:0]  mem [0:65535];

    exp_t        exp_q[$];
    exp_t        got_q[$];
    exp_t        mon_e;
    logic [15:0] m_pc;
    logic        m_halted;
    int          checks = 0;
    int          errors = 0;
    int          base;

    always #5 clk = ~clk;

    // Big-endian combinational instruction memory.
    assign im_data = {mem[im_addr], mem[im_addr + 16'd1]};

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the buffer is a plain queue holding at most BUF_DEPTH words.
    // The monitor has already removed the word decode takes at this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pc     <= RESET_PC;
            m_halted <= 1'b0;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc     <= redirect_pc & 16'hFFFE;
            m_halted <= 1'b0;
        end else begin
            if (!m_halted && exp_q.size() < BUF_DEPTH) begin
                exp_q.push_back('{{mem[m_pc], mem[m_pc + 16'd1]}, m_pc});
                m_pc <= m_pc + 16'd2;
            end
            if (halt_req) m_halted <= 1'b1;
        end
    end

    // Monitor: compare address, status and, on each handshake, the head word.
    always @(negedge clk) begin
        if (rst_n) begin
            check("im_addr", im_addr, m_pc);
            check("halted", halted, m_halted);
            check("instr_valid", instr_valid, exp_q.size() != 0);
            if (exp_q.size() != 0 && instr_ready) begin
                mon_e = exp_q.pop_front();
                check("instr", instr, mon_e.instr);
                check("instr_pc", instr_pc, mon_e.pc);
                got_q.push_back('{instr, instr_pc});
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt_req       = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
        mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;

        // Reset values.
        #1;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_addr", im_addr, RESET_PC);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr_pc", instr_pc, 16'h0000);
        check("rst_halted", halted, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset and stream.
        repeat (4) tick();
        check("stream_count", got_q.size() >= 3, 1'b1);
        if (got_q.size() >= 3) begin
            check("stream_w0", {got_q[0].instr, got_q[0].pc}, 32'h1234_0000);
            check("stream_w1", {got_q[1].instr, got_q[1].pc}, 32'h5678_0002);
            check("stream_w2", {got_q[2].instr, got_q[2].pc}, 32'h9ABC_0004);
        end

        // Backpressure: buffer fills, fetch address holds.
        instr_ready = 1'b0;
        repeat (5) tick();
        check("bp_valid", instr_valid, 1'b1);
        check("bp_hold_addr", im_addr, got_q[$].pc + 16'd6);
        check("bp_head_pc", instr_pc, got_q[$].pc + 16'd2);
        instr_ready = 1'b1;
        repeat (3) tick();

        // Redirect with a full buffer and a pop in the same cycle.
        instr_ready = 1'b0;
        repeat (3) tick();
        base           = got_q.size();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0101;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        @(negedge clk);
        check("redir_popped", got_q.size(), base + 1);
        check("redir_addr", im_addr, 16'h0100);
        check("redir_flushed", instr_valid, 1'b0);
        tick();
        @(negedge clk);
        check("redir_valid", instr_valid, 1'b1);
        check("redir_pc", instr_pc, 16'h0100);
        instr_ready = 1'b1;

        // Wrap-around.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        base = got_q.size();
        repeat (5) tick();
        check("wrap_count", got_q.size() >= base + 3, 1'b1);
        if (got_q.size() >= base + 3) begin
            check("wrap_pc0", got_q[base].pc, 16'hFFFE);
            check("wrap_pc1", got_q[base+1].pc, 16'h0000);
            check("wrap_pc2", got_q[base+2].pc, 16'h0002);
            check("wrap_w0", got_q[base].instr, {mem[16'hFFFE], mem[16'hFFFF]});
        end

        // Halt with two buffered entries, drain, then resume by redirect.
        instr_ready = 1'b0;
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        @(negedge clk);
        check("halt_set", halted, 1'b1);
        base        = got_q.size();
        instr_ready = 1'b1;
        repeat (4) tick();
        check("halt_drained", got_q.size(), base + 2);
        check("halt_empty", instr_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        halt_req       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        @(negedge clk);
        check("halt_cleared", halted, 1'b0);
        check("resume_addr", im_addr, 16'h0200);
        repeat (4) tick();

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        check("arst_valid", instr_valid, 1'b0);
        check("arst_addr", im_addr, RESET_PC);
        check("arst_instr", instr, 16'h0000);
        check("arst_halted", halted, 1'b0);
        #2;
        rst_n = 1'b1;
        repeat (4) tick();

        // Randomised traffic.
        repeat (2000) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFF8 | 16'($urandom_range(0, 7));
            halt_req       = ($urandom_range(0, 29) == 0);
            tick();
        end
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        instr_ready    = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
